// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_blitter
// Description : Copies one sprite ROM into the indexed frame buffer at a signed
//               screen position, skipping transparent (0) and clipped pixels.
//               Optional horizontal mirroring is enabled by BLIT_FLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter #(
    parameter int SPR_W   = 80,
    parameter int SPR_H   = 120,
    parameter int FB_W    = 320,
    parameter int FB_H    = 240,
    parameter int FB_AW   = 17,
    parameter int COORD_W = 10
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               flip,
    output logic               busy,
    output logic               done,
    output logic [15:0]        rom_address,
    input  logic [2:0]         rom_q,
    output logic               fb_we,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [2:0]         fb_data
);

    // Screen coordinates carry enough headroom for any sprite offset.
    localparam int c_PW = COORD_W + 18;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    logic signed [COORD_W-1:0] r_x;
    logic signed [COORD_W-1:0] r_y;
    logic [15:0]               r_col;
    logic [15:0]               r_row;
    logic [15:0]               r_row_base;
    logic                      r_pv;
    logic signed [c_PW-1:0]    r_px;
    logic signed [c_PW-1:0]    r_py;

    logic                      w_last;
    logic                      w_col_wrap;
    logic [15:0]               w_col_off;
    logic signed [c_PW-1:0]    w_px;
    logic signed [c_PW-1:0]    w_py;
    logic                      w_in_bounds;
    logic                      w_write;
    logic [FB_AW-1:0]          w_fb_addr;

`ifdef BLIT_FLIP_EN
    logic r_flip;
    assign w_col_off = r_flip ? (16'(SPR_W - 1) - r_col) : r_col;
`else
    logic w_unused_flip;
    assign w_unused_flip = flip;
    assign w_col_off     = r_col;
`endif

    assign w_col_wrap = (r_col == 16'(SPR_W - 1));
    assign w_last     = w_col_wrap && (r_row == 16'(SPR_H - 1));

    assign w_px = c_PW'(r_x) + c_PW'({1'b0, w_col_off});
    assign w_py = c_PW'(r_y) + c_PW'({1'b0, r_row});

    // Stage aligned with rom_q: bounds test on the delayed coordinate.
    assign w_in_bounds = !r_px[c_PW-1] && (r_px < c_PW'(FB_W)) &&
                         !r_py[c_PW-1] && (r_py < c_PW'(FB_H));
    assign w_write     = r_pv && (rom_q != 3'd0) && w_in_bounds;
    assign w_fb_addr   = FB_AW'(r_py) * FB_AW'(FB_W) + FB_AW'(r_px);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
`ifdef BLIT_FLIP_EN
            r_flip      <= 1'b0;
`endif
            r_col       <= '0;
            r_row       <= '0;
            r_row_base  <= '0;
            r_pv        <= 1'b0;
            r_px        <= '0;
            r_py        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_address <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
        end else begin
            done  <= 1'b0;
            r_pv  <= 1'b0;
            fb_we <= w_write;
            if (w_write) begin
                fb_addr <= w_fb_addr;
                fb_data <= rom_q;
            end

            case (r_state)
                S_IDLE: begin
                    // done is still high in the cycle after DONE; refuse start there.
                    if (start && !done) begin
                        r_x         <= x_pos;
                        r_y         <= y_pos;
`ifdef BLIT_FLIP_EN
                        r_flip      <= flip;
`endif
                        r_col       <= '0;
                        r_row       <= '0;
                        r_row_base  <= '0;
                        rom_address <= '0;
                        busy        <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_pv <= 1'b1;
                    r_px <= w_px;
                    r_py <= w_py;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end else if (w_col_wrap) begin
                        r_col       <= '0;
                        r_row       <= r_row + 16'd1;
                        r_row_base  <= r_row_base + 16'(SPR_W);
                        rom_address <= r_row_base + 16'(SPR_W);
                    end else begin
                        r_col       <= r_col + 16'd1;
                        rom_address <= r_row_base + r_col + 16'd1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
